pll_clk_supervisor: RTL and testbench



---
 rtl/pll_clk_supervisor_if.sv | 10 +
 rtl/pll_clk_supervisor.sv | 239 +++++++++++++++++++++++
 tb/tb_pll_clk_supervisor.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pll_clk_supervisor_if.sv
// Clock-select request/acknowledge handshake between a requester and the PLL supervisor.
interface pll_clk_supervisor_if;
    logic       sel_req;
    logic [2:0] sel_idx;
    logic       sel_ack;
    logic       sel_err;

    modport master (output sel_req, output sel_idx, input sel_ack, input sel_err);
    modport slave  (input sel_req, input sel_idx, output sel_ack, output sel_err);
endinterface

// File: rtl/pll_clk_supervisor.sv
// PLL bring-up sequencer, lock qualifier and glitch-safe measurement clock selector.
module pll_clk_supervisor #(
    parameter int unsigned NUM_CLK      = 5,
    parameter int unsigned RST_CYCLES   = 16,
    parameter int unsigned LOCK_FILTER  = 256,
    parameter int unsigned LOCK_TIMEOUT = 500000,
    parameter int unsigned MAX_RETRIES  = 3,
    parameter int unsigned GATE_CYCLES  = 8
) (
    input  logic                 refclk,
    input  logic                 rst,
    input  logic                 pll_locked,
    output logic                 pll_rst,
    output logic                 sys_rst,
    output logic                 clk_en,
    output logic [2:0]           clk_sel,
    output logic                 ready,
    output logic                 fail,
    output logic [1:0]           retry_cnt,
    output logic [7:0]           lock_loss_cnt,
    pll_clk_supervisor_if.slave  sel_bus
);

    localparam int unsigned IDX_W   = 3;
    localparam int unsigned MAX_AB  = (RST_CYCLES > LOCK_FILTER) ? RST_CYCLES : LOCK_FILTER;
    localparam int unsigned MAX_CD  = (LOCK_TIMEOUT > GATE_CYCLES) ? LOCK_TIMEOUT : GATE_CYCLES;
    localparam int unsigned TMR_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    typedef enum logic [2:0] {
        RESET_PLL,
        WAIT_LOCK,
        FILTER,
        RUN,
        GATE_OFF,
        SWITCH,
        GATE_ON,
        FAIL
    } state_t;

    state_t             state, state_nxt;
    logic [TMR_W-1:0]   timer, timer_nxt;
    logic [IDX_W-1:0]   pend_idx, pend_idx_nxt;
    logic [1:0]         sync;
    logic               lk_s;

    logic               pll_rst_nxt, sys_rst_nxt, clk_en_nxt, ready_nxt, fail_nxt;
    logic [IDX_W-1:0]   clk_sel_nxt;
    logic [1:0]         retry_nxt;
    logic [7:0]         loss_nxt;
    logic               sel_ack_q, sel_err_q, sel_ack_nxt, sel_err_nxt;
    logic               take_req_c, in_gate_c, lock_lost_c;

    assign lk_s            = sync[1];
    assign sel_bus.sel_ack = sel_ack_q;
    assign sel_bus.sel_err = sel_err_q;

    // Two-flop synchronizer for the asynchronous PLL lock indication.
    always_ff @(posedge refclk) begin
        if (rst) begin
            sync <= 2'b00;
        end else begin
            sync <= {sync[0], pll_locked};
        end
    end

    // A request is only taken when the previous acknowledge is not still on the wire.
    always_comb begin
        take_req_c  = sel_bus.sel_req && !sel_ack_q;
        in_gate_c   = (state == GATE_OFF) || (state == SWITCH) || (state == GATE_ON);
        lock_lost_c = !lk_s && ((state == RUN) || in_gate_c);
    end

    // Next-state and next-output logic; lock loss overrides all normal activity.
    always_comb begin
        state_nxt    = state;
        timer_nxt    = timer;
        pend_idx_nxt = pend_idx;
        pll_rst_nxt  = pll_rst;
        sys_rst_nxt  = sys_rst;
        clk_en_nxt   = clk_en;
        clk_sel_nxt  = clk_sel;
        ready_nxt    = ready;
        fail_nxt     = fail;
        retry_nxt    = retry_cnt;
        loss_nxt     = lock_loss_cnt;
        sel_ack_nxt  = 1'b0;
        sel_err_nxt  = 1'b0;

        case (state)
            RESET_PLL: begin
                if (timer == TMR_W'(RST_CYCLES - 1)) begin
                    state_nxt   = WAIT_LOCK;
                    timer_nxt   = '0;
                    pll_rst_nxt = 1'b0;
                end else begin
                    timer_nxt = timer + TMR_W'(1);
                end
            end
            WAIT_LOCK: begin
                if (lk_s) begin
                    state_nxt = FILTER;
                    timer_nxt = '0;
                end else if (timer == TMR_W'(LOCK_TIMEOUT - 1)) begin
                    timer_nxt   = '0;
                    pll_rst_nxt = 1'b1;
                    if (retry_cnt == 2'(MAX_RETRIES)) begin
                        state_nxt = FAIL;
                        fail_nxt  = 1'b1;
                    end else begin
                        state_nxt = RESET_PLL;
                        retry_nxt = retry_cnt + 2'd1;
                    end
                end else begin
                    timer_nxt = timer + TMR_W'(1);
                end
            end
            FILTER: begin
                if (!lk_s) begin
                    state_nxt = WAIT_LOCK;
                    timer_nxt = '0;
                end else if (timer == TMR_W'(LOCK_FILTER - 1)) begin
                    state_nxt   = RUN;
                    timer_nxt   = '0;
                    sys_rst_nxt = 1'b0;
                    clk_en_nxt  = 1'b1;
                    ready_nxt   = 1'b1;
                end else begin
                    timer_nxt = timer + TMR_W'(1);
                end
            end
            RUN: begin
                if (lk_s && take_req_c) begin
                    if (32'(sel_bus.sel_idx) >= NUM_CLK) begin
                        sel_ack_nxt = 1'b1;
                        sel_err_nxt = 1'b1;
                    end else if (sel_bus.sel_idx == clk_sel) begin
                        sel_ack_nxt = 1'b1;
                    end else begin
                        pend_idx_nxt = sel_bus.sel_idx;
                        clk_en_nxt   = 1'b0;
                        state_nxt    = GATE_OFF;
                        timer_nxt    = '0;
                    end
                end
            end
            GATE_OFF: begin
                if (lk_s) begin
                    if (timer == TMR_W'(GATE_CYCLES - 1)) begin
                        state_nxt   = SWITCH;
                        timer_nxt   = '0;
                        clk_sel_nxt = pend_idx;
                    end else begin
                        timer_nxt = timer + TMR_W'(1);
                    end
                end
            end
            SWITCH: begin
                if (lk_s) begin
                    state_nxt = GATE_ON;
                    timer_nxt = '0;
                end
            end
            GATE_ON: begin
                if (lk_s) begin
                    if (timer == TMR_W'(GATE_CYCLES - 1)) begin
                        state_nxt   = RUN;
                        timer_nxt   = '0;
                        clk_en_nxt  = 1'b1;
                        sel_ack_nxt = 1'b1;
                    end else begin
                        timer_nxt = timer + TMR_W'(1);
                    end
                end
            end
            FAIL: begin
                if (take_req_c) begin
                    sel_ack_nxt = 1'b1;
                    sel_err_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = RESET_PLL;
                timer_nxt = '0;
            end
        endcase

        if (lock_lost_c) begin
            state_nxt   = RESET_PLL;
            timer_nxt   = '0;
            pll_rst_nxt = 1'b1;
            sys_rst_nxt = 1'b1;
            clk_en_nxt  = 1'b0;
            ready_nxt   = 1'b0;
            retry_nxt   = 2'd0;
            if (lock_loss_cnt != 8'hFF) begin
                loss_nxt = lock_loss_cnt + 8'd1;
            end
            if (in_gate_c) begin
                sel_ack_nxt = 1'b1;
                sel_err_nxt = 1'b1;
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state         <= RESET_PLL;
            timer         <= '0;
            pend_idx      <= '0;
            pll_rst       <= 1'b1;
            sys_rst       <= 1'b1;
            clk_en        <= 1'b0;
            clk_sel       <= '0;
            ready         <= 1'b0;
            fail          <= 1'b0;
            retry_cnt     <= 2'd0;
            lock_loss_cnt <= 8'd0;
            sel_ack_q     <= 1'b0;
            sel_err_q     <= 1'b0;
        end else begin
            state         <= state_nxt;
            timer         <= timer_nxt;
            pend_idx      <= pend_idx_nxt;
            pll_rst       <= pll_rst_nxt;
            sys_rst       <= sys_rst_nxt;
            clk_en        <= clk_en_nxt;
            clk_sel       <= clk_sel_nxt;
            ready         <= ready_nxt;
            fail          <= fail_nxt;
            retry_cnt     <= retry_nxt;
            lock_loss_cnt <= loss_nxt;
            sel_ack_q     <= sel_ack_nxt;
            sel_err_q     <= sel_err_nxt;
        end
    end

endmodule

// File: tb/tb_pll_clk_supervisor.sv
// Directed bench for pll_clk_supervisor with small timing parameters.
module tb_pll_clk_supervisor;

    localparam int unsigned NUM_CLK      = 5;
    localparam int unsigned RST_CYCLES   = 4;
    localparam int unsigned LOCK_FILTER  = 8;
    localparam int unsigned LOCK_TIMEOUT = 20;
    localparam int unsigned MAX_RETRIES  = 2;
    localparam int unsigned GATE_CYCLES  = 3;

    logic       refclk = 1'b0;
    logic       rst;
    logic       pll_locked;
    logic       pll_rst, sys_rst, clk_en, ready, fail;
    logic [2:0] clk_sel;
    logic [1:0] retry_cnt;
    logic [7:0] lock_loss_cnt;

    pll_clk_supervisor_if sel_bus ();

    pll_clk_supervisor #(
        .NUM_CLK      (NUM_CLK),
        .RST_CYCLES   (RST_CYCLES),
        .LOCK_FILTER  (LOCK_FILTER),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .MAX_RETRIES  (MAX_RETRIES),
        .GATE_CYCLES  (GATE_CYCLES)
    ) dut (
        .refclk        (refclk),
        .rst           (rst),
        .pll_locked    (pll_locked),
        .pll_rst       (pll_rst),
        .sys_rst       (sys_rst),
        .clk_en        (clk_en),
        .clk_sel       (clk_sel),
        .ready         (ready),
        .fail          (fail),
        .retry_cnt     (retry_cnt),
        .lock_loss_cnt (lock_loss_cnt),
        .sel_bus       (sel_bus)
    );

    always #5 refclk = ~refclk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [2:0] idx;
        logic       err;
        int         lat;
        int         lo;
        int         sw_at;
        logic [2:0] sel;
    } sel_vec_t;

    sel_vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge refclk);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_pll_rst"}, 32'(pll_rst), 32'd1);
        check({tag, "_sys_rst"}, 32'(sys_rst), 32'd1);
        check({tag, "_clk_en"},  32'(clk_en), 32'd0);
        check({tag, "_clk_sel"}, 32'(clk_sel), 32'd0);
        check({tag, "_ack"},     32'(sel_bus.sel_ack), 32'd0);
        check({tag, "_err"},     32'(sel_bus.sel_err), 32'd0);
        check({tag, "_ready"},   32'(ready), 32'd0);
        check({tag, "_fail"},    32'(fail), 32'd0);
        check({tag, "_retry"},   32'(retry_cnt), 32'd0);
        check({tag, "_loss"},    32'(lock_loss_cnt), 32'd0);
    endtask

    // Reset is held across several edges and released at a falling edge.
    task automatic do_reset();
        rst = 1'b1;
        sel_bus.sel_req = 1'b0;
        sel_bus.sel_idx = 3'd0;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!ready && n < 200) begin
            tick();
            n++;
        end
        check(name, 32'(ready), 32'd1);
    endtask

    // Global time limit so the bench always terminates.
    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi, first_ready, lat, lo, sw, tout, run;
        logic err_seen, last;
        logic [2:0] prev_sel;
        int hiw [$];
        int low [$];
        int rcq [$];

        vecs[0] = '{idx: 3'd3, err: 1'b0, lat: 8, lo: 7, sw_at: 4, sel: 3'd3};
        vecs[1] = '{idx: 3'd3, err: 1'b0, lat: 1, lo: 0, sw_at: 0, sel: 3'd3};
        vecs[2] = '{idx: 3'd6, err: 1'b1, lat: 1, lo: 0, sw_at: 0, sel: 3'd3};
        vecs[3] = '{idx: 3'd7, err: 1'b1, lat: 1, lo: 0, sw_at: 0, sel: 3'd3};
        vecs[4] = '{idx: 3'd0, err: 1'b0, lat: 8, lo: 7, sw_at: 4, sel: 3'd0};
        vecs[5] = '{idx: 3'd4, err: 1'b0, lat: 8, lo: 7, sw_at: 4, sel: 3'd4};
        vecs[6] = '{idx: 3'd5, err: 1'b1, lat: 1, lo: 0, sw_at: 0, sel: 3'd4};
        vecs[7] = '{idx: 3'd4, err: 1'b0, lat: 1, lo: 0, sw_at: 0, sel: 3'd4};

        // Reset values while rst is held.
        pll_locked = 1'b1;
        rst = 1'b1;
        sel_bus.sel_req = 1'b0;
        sel_bus.sel_idx = 3'd0;
        repeat (3) tick();
        check_reset_vals("rst");

        // Clean bring-up: pll_rst 4 cycles wide, ready 13 edges after release.
        rst = 1'b0;
        hi = 0;
        first_ready = 0;
        for (int n = 0; n <= 20; n++) begin
            if (n > 0) tick();
            if (pll_rst) hi++;
            if (ready && first_ready == 0) first_ready = n;
        end
        check("bringup_pll_rst_width", hi, 4);
        check("bringup_ready_edge", first_ready, 13);
        check("bringup_sys_rst", 32'(sys_rst), 32'd0);
        check("bringup_clk_en", 32'(clk_en), 32'd1);
        check("bringup_retry", 32'(retry_cnt), 32'd0);
        check("bringup_fail", 32'(fail), 32'd0);

        // Clock-select requests in RUN.
        for (int i = 0; i < 8; i++) begin
            lat = 0;
            lo = 0;
            sw = 0;
            err_seen = 1'b0;
            prev_sel = clk_sel;
            sel_bus.sel_req = 1'b1;
            sel_bus.sel_idx = vecs[i].idx;
            for (int n = 1; n <= 30 && lat == 0; n++) begin
                tick();
                if (!clk_en) lo++;
                if (clk_sel != prev_sel && sw == 0) sw = n;
                if (sel_bus.sel_ack) begin
                    lat = n;
                    err_seen = sel_bus.sel_err;
                end
            end
            sel_bus.sel_req = 1'b0;
            check($sformatf("sel%0d_ack_latency", i), lat, vecs[i].lat);
            check($sformatf("sel%0d_err", i), 32'(err_seen), 32'(vecs[i].err));
            check($sformatf("sel%0d_gate_cycles", i), lo, vecs[i].lo);
            check($sformatf("sel%0d_switch_at", i), sw, vecs[i].sw_at);
            check($sformatf("sel%0d_clk_sel", i), 32'(clk_sel), 32'(vecs[i].sel));
            check($sformatf("sel%0d_clk_en", i), 32'(clk_en), 32'd1);
            tick();
        end

        // Abort: lock lost during GATE_OFF.
        do_reset();
        wait_ready("abort_bringup");
        sel_bus.sel_req = 1'b1;
        sel_bus.sel_idx = 3'd2;
        tick();
        check("abort_gate_off_clk_en", 32'(clk_en), 32'd0);
        pll_locked = 1'b0;
        lat = 0;
        err_seen = 1'b0;
        for (int n = 1; n <= 10 && lat == 0; n++) begin
            tick();
            if (sel_bus.sel_ack) begin
                lat = n;
                err_seen = sel_bus.sel_err;
            end
        end
        check("abort_ack_latency", lat, 3);
        check("abort_err", 32'(err_seen), 32'd1);
        check("abort_loss_cnt", 32'(lock_loss_cnt), 32'd1);
        check("abort_sys_rst", 32'(sys_rst), 32'd1);
        check("abort_pll_rst", 32'(pll_rst), 32'd1);
        check("abort_ready", 32'(ready), 32'd0);
        check("abort_clk_sel", 32'(clk_sel), 32'd0);
        sel_bus.sel_req = 1'b0;
        pll_locked = 1'b1;
        wait_ready("abort_relock");
        check("abort_relock_clk_sel", 32'(clk_sel), 32'd0);
        check("abort_relock_retry", 32'(retry_cnt), 32'd0);
        check("abort_relock_loss", 32'(lock_loss_cnt), 32'd1);

        // Lock glitch inside the filter window restarts the full filter.
        do_reset();
        repeat (9) tick();
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        lat = 0;
        hi = 0;
        for (int n = 1; n <= 40 && lat == 0; n++) begin
            tick();
            if (pll_rst || retry_cnt != 2'd0) hi++;
            if (ready) lat = n;
        end
        check("glitch_ready_latency", lat, 11);
        check("glitch_no_retry", hi, 0);

        // Timeout and fail: lock never arrives.
        pll_locked = 1'b0;
        do_reset();
        last = 1'b0;
        run = 0;
        for (int n = 0; n < 300 && !fail; n++) begin
            if (n > 0) tick();
            if (!fail) begin
                if (pll_rst != last) begin
                    if (n > 0) begin
                        if (last) hiw.push_back(run);
                        else low.push_back(run);
                    end
                    if (pll_rst) rcq.push_back(int'(retry_cnt));
                    run = 0;
                    last = pll_rst;
                end
                run++;
            end
        end
        if (!last) low.push_back(run);
        check("fail_reached", 32'(fail), 32'd1);
        check("fail_pulse_count", hiw.size(), 3);
        check("fail_low_count", low.size(), 3);
        for (int k = 0; k < 3; k++) begin
            if (k < hiw.size()) check($sformatf("fail_pulse%0d_width", k), hiw[k], 4);
            if (k < low.size()) check($sformatf("fail_wait%0d_len", k), low[k], 20);
            if (k < rcq.size()) check($sformatf("fail_pulse%0d_retry", k), rcq[k], k);
        end
        check("fail_pll_rst", 32'(pll_rst), 32'd1);
        check("fail_sys_rst", 32'(sys_rst), 32'd1);
        check("fail_clk_en", 32'(clk_en), 32'd0);
        check("fail_retry", 32'(retry_cnt), 32'd2);
        repeat (30) tick();
        check("fail_sticky", 32'(fail), 32'd1);
        check("fail_sticky_pll_rst", 32'(pll_rst), 32'd1);
        sel_bus.sel_req = 1'b1;
        sel_bus.sel_idx = 3'd1;
        lat = 0;
        err_seen = 1'b0;
        for (int n = 1; n <= 5 && lat == 0; n++) begin
            tick();
            if (sel_bus.sel_ack) begin
                lat = n;
                err_seen = sel_bus.sel_err;
            end
        end
        sel_bus.sel_req = 1'b0;
        check("fail_sel_ack_latency", lat, 1);
        check("fail_sel_err", 32'(err_seen), 32'd1);
        check("fail_clk_sel", 32'(clk_sel), 32'd0);

        // Lock-loss counter saturation.
        pll_locked = 1'b1;
        do_reset();
        wait_ready("sat_bringup");
        tout = 0;
        for (int i = 0; i < 260; i++) begin
            pll_locked = 1'b0;
            for (int n = 0; n < 20 && ready; n++) tick();
            if (ready) tout++;
            pll_locked = 1'b1;
            for (int n = 0; n < 100 && !ready; n++) tick();
            if (!ready) tout++;
            if (i == 253) check("sat_loss_254", 32'(lock_loss_cnt), 32'd254);
            if (i == 254) check("sat_loss_255", 32'(lock_loss_cnt), 32'd255);
        end
        check("sat_wait_timeouts", tout, 0);
        check("sat_loss_260", 32'(lock_loss_cnt), 32'd255);
        check("sat_retry", 32'(retry_cnt), 32'd0);

        // Reset in the middle of a switch.
        sel_bus.sel_req = 1'b1;
        sel_bus.sel_idx = 3'd1;
        repeat (4) tick();
        check("midsw_clk_sel", 32'(clk_sel), 32'd1);
        check("midsw_clk_en", 32'(clk_en), 32'd0);
        rst = 1'b1;
        sel_bus.sel_req = 1'b0;
        tick();
        check_reset_vals("midsw_rst");
        rst = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
